// File: rtl/temporizador_coccion_pkg.sv
`default_nettype none
// ============================================================================
// Module  : temporizador_coccion_pkg
// Purpose : Shared types and constants for the cooking countdown timer:
//           FSM state encoding, MM:SS limits and the BCD time record.
// Revision: 1.0 - initial release
// ============================================================================
package temporizador_coccion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MAX_MIN           = 99;
  localparam int MAX_SEC           = 59;
  localparam int SEC_PER_MIN       = 60;
  localparam int QUICK_ADD_SEC_DEF = 30;

  // MM:SS as four BCD digits, most significant first
  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } bcd_time_t;

endpackage
`default_nettype wire

// File: rtl/temporizador_coccion_if.sv
`default_nettype none
// ============================================================================
// Module  : temporizador_coccion_if
// Purpose : Keypad/control inputs and display/status outputs of the timer.
//   key_valid, key_digit  : keypad digit strobe and code
//   start, stop_clear     : one-cycle control pulses
//   door_open             : door level, 1 = open
//   min_tens..sec_ones    : BCD display digits
//   running, fin          : magnetron enable, end-of-cook level
// Revision: 1.0 - initial release
// ============================================================================
interface temporizador_coccion_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop_clear;
  logic       door_open;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       fin;

  modport master (
    output key_valid, key_digit, start, stop_clear, door_open,
    input  min_tens, min_ones, sec_tens, sec_ones, running, fin
  );

  modport slave (
    input  key_valid, key_digit, start, stop_clear, door_open,
    output min_tens, min_ones, sec_tens, sec_ones, running, fin
  );
endinterface
`default_nettype wire

// File: rtl/temporizador_coccion_tick_segundo.sv
`default_nettype none
// ============================================================================
// Module  : tick_segundo
// Purpose : One-second prescaler. Counts 0..TICKS_PER_SEC-1 while enabled and
//           pulses o_tick for one cycle on the terminal count.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (wins over enable)
//   i_en       : count enable; the count holds while low
//   o_tick     : one-cycle pulse on terminal count
// Revision: 1.0 - initial release
// ============================================================================
module tick_segundo #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int                 c_cnt_w = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICKS_PER_SEC - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/temporizador_coccion.sv
`default_nettype none
// ============================================================================
// Module  : temporizador_coccion
// Purpose : Microwave cook timer. Keypad digits shift into MM:SS (BCD), start
//           runs a 1 Hz countdown, fin is raised at 00:00.
//   clock_in, reset_n : clock, asynchronous active-low reset
//   bus (slave)       : keypad/control inputs, display digits, running, fin
// Revision: 1.0 - initial release
// ============================================================================
module temporizador_coccion
  import temporizador_coccion_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int QUICK_ADD_SEC = QUICK_ADD_SEC_DEF
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  temporizador_coccion_if.slave  bus
);

  localparam logic [15:0] c_max_total = 16'(MAX_MIN * SEC_PER_MIN + MAX_SEC);

  // Minutes digits weigh 600 s and 60 s; sec_tens may exceed 5 here (IDLE entry)
  function automatic logic [15:0] to_seconds(input bcd_time_t t);
    return 16'(t.mt) * 16'd600 + 16'(t.mo) * 16'(SEC_PER_MIN)
         + 16'(t.st) * 16'd10  + 16'(t.so);
  endfunction

  // Converts a seconds total back to MM:SS, saturating at 99:59
  function automatic bcd_time_t clamp_time(input logic [15:0] s);
    logic [15:0] v_s, v_m, v_sec;
    bcd_time_t   v_t;
    v_s    = (s > c_max_total) ? c_max_total : s;
    v_m    = v_s / 16'(SEC_PER_MIN);
    v_sec  = v_s % 16'(SEC_PER_MIN);
    v_t.mt = 4'(v_m / 16'd10);
    v_t.mo = 4'(v_m % 16'd10);
    v_t.st = 4'(v_sec / 16'd10);
    v_t.so = 4'(v_sec % 16'd10);
    return v_t;
  endfunction

  // A valid time round-trips unchanged; 60..99 seconds carry into minutes
  function automatic bcd_time_t bcd_normalize(input bcd_time_t t);
    return clamp_time(to_seconds(t));
  endfunction

  function automatic bcd_time_t bcd_add_quick(input bcd_time_t t);
    return clamp_time(to_seconds(t) + 16'(QUICK_ADD_SEC));
  endfunction

  // One-second BCD borrow chain; never called at 00:00
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t v_d;
    v_d = t;
    if (t.so != 4'd0) begin
      v_d.so = t.so - 4'd1;
    end else begin
      v_d.so = 4'd9;
      if (t.st != 4'd0) begin
        v_d.st = t.st - 4'd1;
      end else begin
        v_d.st = 4'd5;
        if (t.mo != 4'd0) begin
          v_d.mo = t.mo - 4'd1;
        end else begin
          v_d.mo = 4'd9;
          v_d.mt = t.mt - 4'd1;
        end
      end
    end
    return v_d;
  endfunction

  state_t    r_state, w_state_nxt;
  bcd_time_t r_time,  w_time_nxt;
  logic      r_running, r_fin;
  logic      w_presc_clr, w_presc_en, w_tick;

  assign w_presc_en = (r_state == ST_RUN);

  tick_segundo #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_tick_segundo (
    .clk    (clock_in),
    .rst_n  (reset_n),
    .i_clr  (w_presc_clr),
    .i_en   (w_presc_en),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_presc_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.stop_clear) begin
          w_time_nxt = '0;
        end else if (bus.start) begin
          // start with the door open is swallowed, keypad included
          if (!bus.door_open) begin
            w_time_nxt  = (r_time == '0) ? clamp_time(16'(QUICK_ADD_SEC))
                                         : bcd_normalize(r_time);
            w_state_nxt = ST_RUN;
            w_presc_clr = 1'b1;
          end
        end else if (bus.key_valid && (bus.key_digit <= 4'd9)) begin
          w_time_nxt = {r_time.mo, r_time.st, r_time.so, bus.key_digit};
        end
      end
      ST_RUN: begin
        if (bus.door_open || bus.stop_clear) begin
          w_state_nxt = ST_PAUSE;
        end else if (bus.start) begin
          // a coincident tick is dropped in favour of the add
          w_time_nxt = bcd_add_quick(r_time);
        end else if (w_tick) begin
          w_time_nxt = bcd_dec(r_time);
          if (w_time_nxt == '0) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.stop_clear) begin
          w_state_nxt = ST_IDLE;
          w_time_nxt  = '0;
        end else if (bus.start && !bus.door_open) begin
          w_state_nxt = ST_RUN;
          w_presc_clr = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.start || bus.stop_clear || bus.key_valid || bus.door_open) begin
          w_state_nxt = ST_IDLE;
          w_time_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_time_nxt  = '0;
      end
    endcase
  end

  // running/fin are registered from the next state so they change on the
  // same edge as the state itself
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_time    <= '0;
      r_running <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_time    <= w_time_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_fin     <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.min_tens = r_time.mt;
  assign bus.min_ones = r_time.mo;
  assign bus.sec_tens = r_time.st;
  assign bus.sec_ones = r_time.so;
  assign bus.running  = r_running;
  assign bus.fin      = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_temporizador_coccion.sv
`default_nettype none
// ============================================================================
// Module  : tb_temporizador_coccion
// Purpose : Self-checking bench for temporizador_coccion: directed scenarios
//           plus randomized keypad/control traffic against a seconds-based
//           reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_temporizador_coccion;

  localparam int T = 4;
  localparam int Q = 30;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clock_in = ~clock_in;

  temporizador_coccion_if bus ();

  temporizador_coccion #(
    .TICKS_PER_SEC (T),
    .QUICK_ADD_SEC (Q)
  ) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] w_disp;
  logic [1:0]  w_rf;
  assign w_disp = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  assign w_rf   = {bus.running, bus.fin};

  // Reference model: time kept as plain minutes/seconds integers
  int m_state, m_mm, m_ss, m_pc;

  function automatic logic [15:0] model_disp();
    return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_mm = 0; m_ss = 0; m_pc = 0;
  endtask

  task automatic set_total(input int tot);
    if (tot > 99 * 60 + 59) tot = 99 * 60 + 59;
    m_mm = tot / 60;
    m_ss = tot % 60;
  endtask

  task automatic model_step(input bit kv, input int kd, input bit stt, input bit sc, input bit door);
    int v;
    bit tick;
    case (m_state)
      M_IDLE: begin
        if (sc) begin
          m_mm = 0; m_ss = 0;
        end else if (stt) begin
          if (!door) begin
            v = m_mm * 60 + m_ss;
            set_total((v == 0) ? Q : v);
            m_state = M_RUN;
            m_pc = 0;
          end
        end else if (kv && kd <= 9) begin
          v = ((m_mm * 100 + m_ss) * 10 + kd) % 10000;
          m_mm = v / 100;
          m_ss = v % 100;
        end
      end
      M_RUN: begin
        m_pc++;
        tick = (m_pc == T);
        if (tick) m_pc = 0;
        if (door || sc) begin
          m_state = M_PAUSE;
        end else if (stt) begin
          set_total(m_mm * 60 + m_ss + Q);
        end else if (tick) begin
          v = m_mm * 60 + m_ss - 1;
          set_total(v);
          if (v == 0) m_state = M_DONE;
        end
      end
      M_PAUSE: begin
        if (sc) begin
          m_state = M_IDLE; m_mm = 0; m_ss = 0;
        end else if (stt && !door) begin
          m_state = M_RUN; m_pc = 0;
        end
      end
      default: begin
        if (kv || stt || sc || door) begin
          m_state = M_IDLE; m_mm = 0; m_ss = 0;
        end
      end
    endcase
  endtask

  // One clock of stimulus; pulses are dropped again 1 time unit after the edge
  task automatic step(input bit kv, input logic [3:0] kd, input bit stt, input bit sc);
    bus.key_valid  = kv;
    bus.key_digit  = kd;
    bus.start      = stt;
    bus.stop_clear = sc;
    @(posedge clock_in);
    model_step(kv, int'(kd), stt, sc, bus.door_open);
    #1;
    bus.key_valid  = 1'b0;
    bus.start      = 1'b0;
    bus.stop_clear = 1'b0;
  endtask

  task automatic idle();             step(1'b0, 4'd0, 1'b0, 1'b0); endtask
  task automatic key(input logic [3:0] d); step(1'b1, d, 1'b0, 1'b0); endtask
  task automatic press_start();      step(1'b0, 4'd0, 1'b1, 1'b0); endtask
  task automatic press_stop();       step(1'b0, 4'd0, 1'b0, 1'b1); endtask

  task automatic test_reset();
    bus.key_valid = 1'b0; bus.key_digit = 4'd0; bus.start = 1'b0;
    bus.stop_clear = 1'b0; bus.door_open = 1'b0;
    model_reset();
    #1;
    compared++; if (w_disp !== 16'h0000) begin mismatched++; $display("FAIL reset_disp: got %h want 0000", w_disp); end
    compared++; if (w_rf !== 2'b00) begin mismatched++; $display("FAIL reset_flags: got %b want 00", w_rf); end
    @(posedge clock_in); @(posedge clock_in); #1;
    reset_n = 1'b1;
    idle();
    compared++; if (w_disp !== 16'h0000 || w_rf !== 2'b00) begin mismatched++; $display("FAIL post_reset: got %h/%b want 0000/00", w_disp, w_rf); end
  endtask

  task automatic test_countdown();
    key(4'd1); key(4'd3); key(4'd0); press_start();
    compared++; if (w_disp !== 16'h0130 || w_rf !== 2'b10) begin mismatched++; $display("FAIL entry_start: got %h/%b want 0130/10", w_disp, w_rf); end
    repeat (4) idle();
    compared++; if (w_disp !== 16'h0129) begin mismatched++; $display("FAIL first_tick: got %h want 0129", w_disp); end
    repeat (236) idle();
    compared++; if (w_disp !== 16'h0030) begin mismatched++; $display("FAIL sixty_ticks: got %h want 0030", w_disp); end
    repeat (119) idle();
    compared++; if (w_disp !== 16'h0001 || w_rf !== 2'b10) begin mismatched++; $display("FAIL before_done: got %h/%b want 0001/10", w_disp, w_rf); end
    idle();
    compared++; if (w_disp !== 16'h0000 || w_rf !== 2'b01) begin mismatched++; $display("FAIL done_edge: got %h/%b want 0000/01", w_disp, w_rf); end
    key(4'd5);
    compared++; if (w_disp !== 16'h0000 || w_rf !== 2'b00) begin mismatched++; $display("FAIL done_exit: got %h/%b want 0000/00", w_disp, w_rf); end
    idle();
    compared++; if (w_disp !== 16'h0000) begin mismatched++; $display("FAIL exit_key_not_shifted: got %h want 0000", w_disp); end
  endtask

  task automatic test_normalize();
    key(4'd0); key(4'd0); key(4'd9); key(4'd0); press_start();
    compared++; if (w_disp !== 16'h0130 || w_rf !== 2'b10) begin mismatched++; $display("FAIL norm_90s: got %h/%b want 0130/10", w_disp, w_rf); end
    press_stop(); press_stop();
    compared++; if (w_disp !== 16'h0000 || w_rf !== 2'b00) begin mismatched++; $display("FAIL stop_twice: got %h/%b want 0000/00", w_disp, w_rf); end
    key(4'd9); key(4'd9); key(4'd9); key(4'd9); press_start();
    compared++; if (w_disp !== 16'h9959 || w_rf !== 2'b10) begin mismatched++; $display("FAIL norm_clamp: got %h/%b want 9959/10", w_disp, w_rf); end
    press_stop(); press_stop();
    press_start();
    compared++; if (w_disp !== 16'h0030 || w_rf !== 2'b10) begin mismatched++; $display("FAIL start_at_zero: got %h/%b want 0030/10", w_disp, w_rf); end
    press_stop(); press_stop();
    key(4'd1); key(4'hC);
    compared++; if (w_disp !== 16'h0001) begin mismatched++; $display("FAIL key_above_9: got %h want 0001", w_disp); end
    press_stop();
  endtask

  task automatic test_door_pause();
    key(4'd4); key(4'd5); press_start(); idle(); idle();
    bus.door_open = 1'b1;
    idle();
    compared++; if (w_disp !== 16'h0045 || w_rf !== 2'b00) begin mismatched++; $display("FAIL door_pause: got %h/%b want 0045/00", w_disp, w_rf); end
    repeat (5) idle();
    compared++; if (w_disp !== 16'h0045) begin mismatched++; $display("FAIL door_frozen: got %h want 0045", w_disp); end
    bus.door_open = 1'b0;
    press_start();
    compared++; if (w_rf !== 2'b10) begin mismatched++; $display("FAIL resume: got %b want 10", w_rf); end
    repeat (3) idle();
    compared++; if (w_disp !== 16'h0045) begin mismatched++; $display("FAIL resume_early: got %h want 0045", w_disp); end
    idle();
    compared++; if (w_disp !== 16'h0044) begin mismatched++; $display("FAIL resume_tick: got %h want 0044", w_disp); end
    press_stop(); press_stop();
  endtask

  task automatic test_quick_add();
    key(4'd1); key(4'd0); press_start(); press_start();
    compared++; if (w_disp !== 16'h0040) begin mismatched++; $display("FAIL add_30: got %h want 0040", w_disp); end
    press_stop(); press_stop();
    key(4'd9); key(4'd9); key(4'd4); key(4'd5); press_start(); press_start();
    compared++; if (w_disp !== 16'h9959) begin mismatched++; $display("FAIL add_clamp: got %h want 9959", w_disp); end
    press_stop(); press_stop();
    key(4'd1); key(4'd0); press_start(); repeat (3) idle(); press_start();
    compared++; if (w_disp !== 16'h0040) begin mismatched++; $display("FAIL add_over_tick: got %h want 0040", w_disp); end
    repeat (4) idle();
    compared++; if (w_disp !== 16'h0039) begin mismatched++; $display("FAIL tick_after_add: got %h want 0039", w_disp); end
    press_stop(); press_stop();
  endtask

  task automatic test_pause_clear();
    key(4'd2); key(4'd0); press_start(); press_stop();
    compared++; if (w_disp !== 16'h0020 || w_rf !== 2'b00) begin mismatched++; $display("FAIL stop_pause: got %h/%b want 0020/00", w_disp, w_rf); end
    press_stop();
    compared++; if (w_disp !== 16'h0000 || w_rf !== 2'b00) begin mismatched++; $display("FAIL pause_clear: got %h/%b want 0000/00", w_disp, w_rf); end
  endtask

  task automatic test_reset_mid_run();
    key(4'd1); key(4'd1); key(4'd0); press_start();
    compared++; if (w_disp !== 16'h0110) begin mismatched++; $display("FAIL pre_reset_run: got %h want 0110", w_disp); end
    idle(); idle();
    reset_n = 1'b0;
    #1;
    model_reset();
    compared++; if (w_disp !== 16'h0000 || w_rf !== 2'b00) begin mismatched++; $display("FAIL async_reset: got %h/%b want 0000/00", w_disp, w_rf); end
    @(posedge clock_in); #1;
    reset_n = 1'b1;
    repeat (10) idle();
    compared++; if (w_disp !== 16'h0000 || w_rf !== 2'b00) begin mismatched++; $display("FAIL after_reset_idle: got %h/%b want 0000/00", w_disp, w_rf); end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] exp_rf;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 3) bus.door_open = ~bus.door_open;
      r = int'($urandom_range(0, 99));
      step(r < 15, 4'($urandom_range(0, 15)), (r >= 15) && (r < 18), (r >= 18) && (r < 20));
      exp_rf = {m_state == M_RUN, m_state == M_DONE};
      compared++;
      if (w_disp !== model_disp() || w_rf !== exp_rf) begin
        mismatched++;
        $display("FAIL random[%0d]: got %h/%b want %h/%b", i, w_disp, w_rf, model_disp(), exp_rf);
      end
    end
    bus.door_open = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_normalize();
    test_door_pause();
    test_quick_add();
    test_pause_clear();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/temporizador_coccion.md
Name: temporizador_coccion

Overview:
- Cooking countdown timer for the microwave controller. Holds the MM:SS cook time in BCD. The time is entered digit by digit from the keypad and counted down at 1 Hz while the door is closed.
- Drives the magnetron enable (`running`) and the display digits.
- Raises `fin` when the count reaches 00:00. `fin` feeds the end-of-cook beep counter directly downstream.

Parameters:
- TICKS_PER_SEC, 50_000_000, clock_in cycles per one-second decrement (bench uses 4).
- QUICK_ADD_SEC, 30, seconds added by start in RUN and loaded by start at 00:00 in IDLE.

Ports:
- clock_in  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- key_valid  input  1  one-cycle pulse, debounced keypad digit strobe
- key_digit  input  4  keypad code; only 0..9 are digits, others ignored
- start  input  1  one-cycle pulse, start/resume/+30 s
- stop_clear  input  1  one-cycle pulse, pause or clear
- door_open  input  1  level, 1 = door open
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD display digits
- running  output  1  magnetron enable; 1 only in RUN
- fin  output  1  level, 1 only in DONE

Behaviour:
- Reset (async, reset_n=0): state IDLE, all digits 0, prescaler 0, running=0, fin=0. Reset mid-RUN aborts immediately with the same values.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered. Per-cycle event priority: door_open > stop_clear > start > key_valid > tick.
- IDLE:
  - key_valid with digit ≤9 shifts left: {mt,mo,st,so} <= {mo,st,so,digit}. Codes >9 are ignored.
  - stop_clear clears the digits to 00:00.
  - start with door_open=0:
    - If time = 00:00, load 00:QUICK_ADD_SEC.
    - Else if sec_tens>5, normalize: sec -= 60 and min += 1. If min was 99, clamp to 99:59.
    - Enter RUN and clear the prescaler. Normalization and the state change land on the same edge.
  - start with door_open=1 is ignored.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1. At terminal count the time decrements by one second in BCD:
    - so borrows from st (wraps 0→9).
    - st borrows from mo (0→5).
    - mo borrows from mt (0→9).
  - The first decrement comes exactly TICKS_PER_SEC cycles after the start edge.
  - A decrement that produces 00:00 moves to DONE on that same edge. `fin` is 1 from that edge on.
  - door_open=1 or stop_clear → PAUSE. Digits are frozen; the prescaler holds its value and is cleared on resume.
  - start → add QUICK_ADD_SEC with carry, clamped to 99:59; stay in RUN. If start and tick coincide, only the add applies and the tick is dropped.
  - key_valid is ignored.
- PAUSE:
  - start with door_open=0 → RUN, prescaler cleared.
  - stop_clear → IDLE with digits 00:00.
  - key_valid is ignored.
- DONE:
  - Display 00:00, fin=1, running=0.
  - Any of start, stop_clear, key_valid, or door_open=1 → IDLE, fin=0. The key that causes the exit is not shifted in.
- Arithmetic is BCD only; the digits never hold values >9. sec_tens >5 is legal only in IDLE, before normalization.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - constants: MAX_MIN=99, MAX_SEC=59, SEC_PER_MIN=60, QUICK_ADD_SEC default
  - a BCD MM:SS struct type
- One sub-module, tick_segundo: prescaler with clear/enable inputs and a one-cycle tick output, parameterized by TICKS_PER_SEC.
- BCD decrement, add and normalize stay in temporizador_coccion as functions.

Test Plan:
- Reset: assert reset_n=0 mid-RUN at 01:10 → digits 00:00, running=0, fin=0 asynchronously; no decrement after release.
- Entry and countdown:
  - Keys 1,3,0 then start → 01:30, running=1.
  - 4 cycles later → 01:29; after 60 ticks → 00:30.
  - After 360 cycles total → 00:00, fin=1, running=0 on the same edge.
- Normalize:
  - Keys 0,0,9,0 then start → 01:30 on the next edge.
  - Keys 9,9,9,9 then start → 99:59.
  - start at 00:00 in IDLE → 00:30 and RUN.
- Door pause: RUN at 00:45, door_open=1 → running=0, digits stay 00:45. Then door_open=0 plus start → RUN; 00:44 exactly 4 cycles later.
- Quick add in RUN:
  - 00:10 + start → 00:40.
  - 99:45 + start → 99:59.
  - start coinciding with a tick at 00:10 → 00:40, not 00:39.
- DONE exit: in DONE, key_valid with digit 5 → IDLE, fin=0, digits 00:00 (the 5 is not shifted). stop_clear in PAUSE at 00:20 → IDLE 00:00.
